// File: rtl/qbu_frag_reassembler.sv
// Reassembles Qbu preemptable-MAC fragments (SMD-S start, SMD-C continuation) into whole frames.
// Define REASM_TIMEOUT_EN to abort a frame whose continuation fails to arrive within TIMEOUT_CYCLES.
module qbu_frag_reassembler #(
   parameter int unsigned DWIDTH         = 8,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [DWIDTH-1:0]   i_Pmac_rx_axis_data,
   input  logic [15:0]         i_Pmac_rx_axis_user,
   input  logic [DWIDTH/8-1:0] i_Pmac_rx_axis_keep,
   input  logic                i_Pmac_rx_axis_last,
   input  logic                i_Pmac_rx_axis_valid,
   output logic                o_Pmac_rx_axis_ready,
   output logic [DWIDTH-1:0]   o_Pframe_axis_data,
   output logic [15:0]         o_Pframe_axis_user,
   output logic [DWIDTH/8-1:0] o_Pframe_axis_keep,
   output logic                o_Pframe_axis_last,
   output logic                o_Pframe_axis_valid,
   input  logic                i_Pframe_axis_ready,
   output logic [15:0]         o_reasm_ok_cnt,
   output logic [15:0]         o_reasm_err_cnt
);

   typedef enum logic [1:0] {StIdle, StAssemble, StWaitCont, StDrop} state_t;

   state_t              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [1:0]          exp_cnt_q, exp_cnt_d;
   logic [11:0]         len_q, len_d, len_inc;
   logic [DWIDTH-1:0]   hold_data_q, hold_data_d;
   logic [DWIDTH/8-1:0] hold_keep_q, hold_keep_d;
   logic                hold_vld_q, hold_vld_d;

   logic                emit, emit_last;
   logic [DWIDTH-1:0]   emit_data;
   logic [DWIDTH/8-1:0] emit_keep;
   logic [15:0]         emit_user, err_user;
   logic                ok_inc, err_inc, in_ready;

   logic                info_vld, is_mcrc, is_s, is_c, slot_free;
   logic [7:0]          smd;
   logic [1:0]          frag_cnt, s_idx, c_idx;

`ifdef REASM_TIMEOUT_EN
   logic [15:0]         timer_q, timer_d;
   logic                timer_at_lim;
   assign timer_at_lim = (timer_q == TIMEOUT_CYCLES - 16'd1);
   logic                unused_bits;
   assign unused_bits = ^i_Pmac_rx_axis_user[2:0];
`else
   logic                unused_bits;
   assign unused_bits = ^{i_Pmac_rx_axis_user[2:0], TIMEOUT_CYCLES};
`endif

   assign info_vld  = i_Pmac_rx_axis_user[15];
   assign smd       = i_Pmac_rx_axis_user[14:7];
   assign frag_cnt  = i_Pmac_rx_axis_user[6:5];
   assign is_mcrc   = (i_Pmac_rx_axis_user[4:3] == 2'b10);
   assign slot_free = !o_Pframe_axis_valid || i_Pframe_axis_ready;
   assign len_inc   = (len_q == 12'hFFF) ? len_q : len_q + 12'd1;
   assign err_user  = {1'b1, idx_q, 1'b0, len_q};

   // Ready is held low while reset is asserted so every output reads 0.
   assign o_Pmac_rx_axis_ready = in_ready & ~i_rst;

   always_comb begin
      is_s  = 1'b0;
      is_c  = 1'b0;
      s_idx = 2'd0;
      c_idx = 2'd0;
      if (info_vld) begin
         case (smd)
            8'hE6: begin is_s = 1'b1; s_idx = 2'd0; end
            8'h4C: begin is_s = 1'b1; s_idx = 2'd1; end
            8'h7F: begin is_s = 1'b1; s_idx = 2'd2; end
            8'hB3: begin is_s = 1'b1; s_idx = 2'd3; end
            8'h61: begin is_c = 1'b1; c_idx = 2'd0; end
            8'h52: begin is_c = 1'b1; c_idx = 2'd1; end
            8'h9E: begin is_c = 1'b1; c_idx = 2'd2; end
            8'h2A: begin is_c = 1'b1; c_idx = 2'd3; end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      exp_cnt_d   = exp_cnt_q;
      len_d       = len_q;
      hold_data_d = hold_data_q;
      hold_keep_d = hold_keep_q;
      hold_vld_d  = hold_vld_q;
      in_ready    = 1'b0;
      emit        = 1'b0;
      emit_data   = i_Pmac_rx_axis_data;
      emit_keep   = i_Pmac_rx_axis_keep;
      emit_last   = 1'b0;
      emit_user   = 16'h0;
      ok_inc      = 1'b0;
      err_inc     = 1'b0;
`ifdef REASM_TIMEOUT_EN
      timer_d     = timer_q;
`endif
      unique case (state_q)
         StIdle: begin
            in_ready = slot_free;
            if (i_Pmac_rx_axis_valid && slot_free) begin
               if (is_s) begin
                  idx_d     = s_idx;
                  exp_cnt_d = 2'd0;
                  len_d     = 12'd1;
                  if (!i_Pmac_rx_axis_last) begin
                     emit    = 1'b1;
                     state_d = StAssemble;
                  end else if (is_mcrc) begin
                     hold_data_d = i_Pmac_rx_axis_data;
                     hold_keep_d = i_Pmac_rx_axis_keep;
                     hold_vld_d  = 1'b1;
                     state_d     = StWaitCont;
`ifdef REASM_TIMEOUT_EN
                     timer_d     = 16'd0;
`endif
                  end else begin
                     emit      = 1'b1;
                     emit_last = 1'b1;
                     emit_user = {1'b0, s_idx, 1'b0, 12'd1};
                     ok_inc    = 1'b1;
                  end
               end else begin
                  // A single-beat orphan is fully consumed here; longer ones drain in DROP.
                  err_inc = 1'b1;
                  if (!i_Pmac_rx_axis_last) state_d = StDrop;
               end
            end
         end
         StAssemble: begin
            in_ready = slot_free;
            if (i_Pmac_rx_axis_valid && slot_free) begin
               len_d = len_inc;
               if (!i_Pmac_rx_axis_last) begin
                  emit = 1'b1;
               end else if (is_mcrc) begin
                  hold_data_d = i_Pmac_rx_axis_data;
                  hold_keep_d = i_Pmac_rx_axis_keep;
                  hold_vld_d  = 1'b1;
                  state_d     = StWaitCont;
`ifdef REASM_TIMEOUT_EN
                  timer_d     = 16'd0;
`endif
               end else begin
                  emit      = 1'b1;
                  emit_last = 1'b1;
                  emit_user = {1'b0, idx_q, 1'b0, len_inc};
                  ok_inc    = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         StWaitCont: begin
            // The incoming beat only steers the held byte; it is consumed after the transition.
            if (i_Pmac_rx_axis_valid && slot_free) begin
               emit       = 1'b1;
               emit_data  = hold_data_q;
               emit_keep  = hold_keep_q;
               hold_vld_d = 1'b0;
               if (is_c && (c_idx == idx_q) && (frag_cnt == exp_cnt_q)) begin
                  exp_cnt_d = exp_cnt_q + 2'd1;
                  state_d   = StAssemble;
               end else begin
                  emit_last = 1'b1;
                  emit_user = err_user;
                  err_inc   = 1'b1;
                  state_d   = is_s ? StIdle : StDrop;
               end
            end
`ifdef REASM_TIMEOUT_EN
            else if (!i_Pmac_rx_axis_valid && slot_free && timer_at_lim) begin
               emit       = 1'b1;
               emit_data  = hold_data_q;
               emit_keep  = hold_keep_q;
               emit_last  = 1'b1;
               emit_user  = err_user;
               hold_vld_d = 1'b0;
               err_inc    = 1'b1;
               state_d    = StIdle;
            end
            if (!timer_at_lim) timer_d = timer_q + 16'd1;
`endif
         end
         StDrop: begin
            in_ready = 1'b1;
            if (i_Pmac_rx_axis_valid && i_Pmac_rx_axis_last) state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q             <= StIdle;
         idx_q               <= 2'd0;
         exp_cnt_q           <= 2'd0;
         len_q               <= 12'd0;
         hold_data_q         <= '0;
         hold_keep_q         <= '0;
         hold_vld_q          <= 1'b0;
         o_Pframe_axis_data  <= '0;
         o_Pframe_axis_user  <= 16'h0;
         o_Pframe_axis_keep  <= '0;
         o_Pframe_axis_last  <= 1'b0;
         o_Pframe_axis_valid <= 1'b0;
         o_reasm_ok_cnt      <= 16'h0;
         o_reasm_err_cnt     <= 16'h0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         exp_cnt_q   <= exp_cnt_d;
         len_q       <= len_d;
         hold_data_q <= hold_data_d;
         hold_keep_q <= hold_keep_d;
         hold_vld_q  <= hold_vld_d;
         if (emit) begin
            o_Pframe_axis_data  <= emit_data;
            o_Pframe_axis_user  <= emit_user;
            o_Pframe_axis_keep  <= emit_keep;
            o_Pframe_axis_last  <= emit_last;
            o_Pframe_axis_valid <= 1'b1;
         end else if (i_Pframe_axis_ready) begin
            o_Pframe_axis_valid <= 1'b0;
         end
         if (ok_inc)  o_reasm_ok_cnt  <= o_reasm_ok_cnt + 16'd1;
         if (err_inc) o_reasm_err_cnt <= o_reasm_err_cnt + 16'd1;
      end
   end

`ifdef REASM_TIMEOUT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) timer_q <= 16'd0;
      else       timer_q <= timer_d;
   end
`endif

endmodule

// File: tb/tb_qbu_frag_reassembler.sv
// Directed scoreboard bench for qbu_frag_reassembler; expected output beats are queued as
// fragments are driven and popped by an output monitor.
module tb_qbu_frag_reassembler;

   localparam logic [1:0] CRC  = 2'b01;
   localparam logic [1:0] MCRC = 2'b10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = '0;
   logic [15:0] in_user = '0;
   logic        in_keep = 1'b1;
   logic        in_last = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  o_data;
   logic [15:0] o_user;
   logic        o_keep, o_last, o_valid;
   logic        out_rdy = 1'b1;
   logic [15:0] ok_cnt, err_cnt;

   int          n_chk = 0;
   int          n_pass = 0;
   bit          toggle = 1'b0;
   logic [25:0] sb[$];

   always #5 clk = ~clk;

   qbu_frag_reassembler #(
      .DWIDTH        (8),
      .TIMEOUT_CYCLES(16'd16)
   ) dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_Pmac_rx_axis_data (in_data),
      .i_Pmac_rx_axis_user (in_user),
      .i_Pmac_rx_axis_keep (in_keep),
      .i_Pmac_rx_axis_last (in_last),
      .i_Pmac_rx_axis_valid(in_valid),
      .o_Pmac_rx_axis_ready(in_ready),
      .o_Pframe_axis_data  (o_data),
      .o_Pframe_axis_user  (o_user),
      .o_Pframe_axis_keep  (o_keep),
      .o_Pframe_axis_last  (o_last),
      .o_Pframe_axis_valid (o_valid),
      .i_Pframe_axis_ready (out_rdy),
      .o_reasm_ok_cnt      (ok_cnt),
      .o_reasm_err_cnt     (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] mk_user(input logic [7:0] smd, input logic [1:0] cnt,
                                           input logic [1:0] crc);
      return {1'b1, smd, cnt, crc, 3'b000};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle) out_rdy = ~out_rdy;
   endtask

   task automatic exp_frag(input int n, input logic [7:0] base, input logic lst,
                           input logic [15:0] user);
      for (int i = 0; i < n; i++) begin
         logic is_end;
         is_end = (i == n - 1) && lst;
         sb.push_back({base + 8'(i), 1'b1, is_end, is_end ? user : 16'h0});
      end
   endtask

   task automatic send_frag(input logic [15:0] user, input int n, input logic [7:0] base,
                            output int stalls);
      stalls = 0;
      for (int i = 0; i < n; i++) begin
         int g;
         in_valid = 1'b1;
         in_user  = user;
         in_data  = base + 8'(i);
         in_keep  = 1'b1;
         in_last  = (i == n - 1);
         g = 0;
         while (1) begin
            @(negedge clk);
            if (in_ready) begin
               tick();
               break;
            end
            stalls++;
            g++;
            tick();
            if (g > 1000) begin
               check("input_handshake_timeout", 32'(in_ready), 32'd1);
               break;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 3000) begin
         tick();
         g++;
      end
      check("drain_queue_left", 32'(sb.size()), 32'd0);
      repeat (4) tick();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      toggle   = 1'b0;
      out_rdy  = 1'b1;
      tick();
      tick();
      sb.delete();
      rst = 1'b0;
      tick();
   endtask

   always @(negedge clk) begin
      if (!rst && o_valid && out_rdy) begin
         if (sb.size() == 0) begin
            check("extra_out_beat_queue", 32'(sb.size()), 32'd1);
         end else begin
            logic [25:0] e;
            e = sb.pop_front();
            check("out_beat", {6'h0, o_data, o_keep, o_last, o_user}, {6'h0, e});
         end
      end
   end

   initial begin
      int st;
      int cnt;

      // Reset values
      tick();
      check("reset_out_ctrl", {14'h0, o_valid, in_ready, o_user}, 32'h0);
      check("reset_cnts", {ok_cnt, err_cnt}, 32'h0);
      rst = 1'b0;
      tick();
      check("ready_after_reset", 32'(in_ready), 32'd1);

      // Reset mid-frame drops the registered beat
      out_rdy  = 1'b0;
      in_valid = 1'b1;
      in_user  = mk_user(8'hE6, 2'd0, CRC);
      in_data  = 8'hAA;
      in_last  = 1'b0;
      @(negedge clk);
      tick();
      in_valid = 1'b0;
      check("held_beat_before_reset", 32'(o_valid), 32'd1);
      rst = 1'b1;
      tick();
      check("reset_clears_valid", 32'(o_valid), 32'd0);

      // S0 CRC 60B
      do_reset();
      exp_frag(60, 8'h10, 1'b1, 16'h003C);
      send_frag(mk_user(8'hE6, 2'd0, CRC), 60, 8'h10, st);
      drain();
      check("c1_ok_cnt", 32'(ok_cnt), 32'd1);

      // S1 mCRC 64B + C1 cnt0 CRC 40B
      do_reset();
      exp_frag(64, 8'h00, 1'b0, 16'h0);
      exp_frag(40, 8'h40, 1'b1, 16'h2068);
      send_frag(mk_user(8'h4C, 2'd0, MCRC), 64, 8'h00, st);
      send_frag(mk_user(8'h52, 2'd0, CRC), 40, 8'h40, st);
      drain();
      check("c2_cnts", {ok_cnt, err_cnt}, {16'd1, 16'd0});

      // S0 mCRC 64B + C0 with wrong frag_cnt
      do_reset();
      exp_frag(64, 8'h20, 1'b1, 16'h8040);
      send_frag(mk_user(8'hE6, 2'd0, MCRC), 64, 8'h20, st);
      send_frag(mk_user(8'h61, 2'd1, CRC), 12, 8'h70, st);
      drain();
      check("c3_cnts", {ok_cnt, err_cnt}, {16'd0, 16'd1});

      // Orphan C2 30B in IDLE, then S3 CRC 10B
      do_reset();
      send_frag(mk_user(8'h9E, 2'd0, CRC), 30, 8'h80, st);
      check("c4_orphan_ready_stalls", 32'(st), 32'd0);
      exp_frag(10, 8'hC0, 1'b1, 16'h600A);
      send_frag(mk_user(8'hB3, 2'd0, CRC), 10, 8'hC0, st);
      drain();
      check("c4_cnts", {ok_cnt, err_cnt}, {16'd1, 16'd1});

      // S2 mCRC 20B interrupted by S0 CRC 10B
      do_reset();
      exp_frag(20, 8'h30, 1'b1, 16'hC014);
      exp_frag(10, 8'h50, 1'b1, 16'h000A);
      send_frag(mk_user(8'h7F, 2'd0, MCRC), 20, 8'h30, st);
      send_frag(mk_user(8'hE6, 2'd0, CRC), 10, 8'h50, st);
      drain();
      check("c5_cnts", {ok_cnt, err_cnt}, {16'd1, 16'd1});

      // Case 2 frame under toggling downstream ready
      do_reset();
      toggle = 1'b1;
      exp_frag(64, 8'h00, 1'b0, 16'h0);
      exp_frag(40, 8'h40, 1'b1, 16'h2068);
      send_frag(mk_user(8'h4C, 2'd0, MCRC), 64, 8'h00, st);
      send_frag(mk_user(8'h52, 2'd0, CRC), 40, 8'h40, st);
      drain();
      check("c6_cnts", {ok_cnt, err_cnt}, {16'd1, 16'd0});
      toggle  = 1'b0;
      out_rdy = 1'b1;

      // Continuation wait: aborts on timeout when enabled, otherwise waits indefinitely
      do_reset();
`ifdef REASM_TIMEOUT_EN
      exp_frag(8, 8'h90, 1'b1, 16'h8008);
      send_frag(mk_user(8'hE6, 2'd0, MCRC), 8, 8'h90, st);
      cnt = 0;
      while (!(o_valid && o_last) && cnt < 100) begin
         tick();
         cnt++;
      end
      check("timeout_latency", 32'(cnt), 32'd16);
      drain();
      check("timeout_cnts", {ok_cnt, err_cnt}, {16'd0, 16'd1});
`else
      exp_frag(8, 8'h90, 1'b0, 16'h0);
      exp_frag(2, 8'hA0, 1'b1, 16'h000A);
      send_frag(mk_user(8'hE6, 2'd0, MCRC), 8, 8'h90, st);
      cnt = 0;
      repeat (40) begin
         tick();
         cnt++;
      end
      check("wait_cont_held_queue", 32'(sb.size()), 32'd3);
      send_frag(mk_user(8'h61, 2'd0, CRC), 2, 8'hA0, st);
      drain();
      check("wait_cont_cnts", {ok_cnt, err_cnt}, {16'd1, 16'd0});
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
